// File: rtl/ring_decoder.sv
// Receive-side decoder for a right-rotating 4-bit one-hot ring code.
// Decodes the phase index, flags invalid or out-of-order codes, and tracks lock and revolutions.
module ring_decoder #(
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned REV_W    = 8,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [3:0]       ring_in,
  output logic [1:0]       idx,
  output logic             idx_valid,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             locked,
  output logic [REV_W-1:0] rev_count,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned RING_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [RING_W-1:0]   prev_q, prev_d;
  logic                have_prev_q, have_prev_d;
  logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic                idx_valid_q, idx_valid_d;
  logic                onehot_err_q, onehot_err_d;
  logic                seq_err_q, seq_err_d;
  logic [REV_W-1:0]    rev_count_q, rev_count_d;
  logic [ERR_W-1:0]    err_count_q, err_count_d;

  logic                is_onehot_c;
  logic                match_c;
  logic                lock_hit_c;
  logic [RING_W-1:0]   expected_c;
  logic [1:0]          enc_c;
  logic [ERR_W-1:0]    err_inc_c;

  // Sample classification against the right rotation of the last valid code.
  assign is_onehot_c = (ring_in != 4'd0) && ((ring_in & (ring_in - 4'd1)) == 4'd0);
  assign expected_c  = {prev_q[0], prev_q[3:1]};
  assign match_c     = have_prev_q && (ring_in == expected_c);
  assign lock_hit_c  = (match_cnt_q + CNT_W'(1)) == CNT_W'(LOCK_CNT);
  assign err_inc_c   = (err_count_q == {ERR_W{1'b1}}) ? err_count_q
                                                      : err_count_q + ERR_W'(1);

  always_comb begin
    enc_c = 2'd0;
    case (ring_in)
      4'b0010: enc_c = 2'd1;
      4'b0100: enc_c = 2'd2;
      4'b1000: enc_c = 2'd3;
      default: enc_c = 2'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!clr_n) state_q <= ST_UNLOCK;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (en) begin
      if (!is_onehot_c)                              state_d = ST_UNLOCK;
      else if (!have_prev_q)                         state_d = ST_TRACK;
      else if (!match_c)                             state_d = ST_TRACK;
      else if (state_q == ST_TRACK && lock_hit_c)    state_d = ST_LOCKED;
    end
  end

  // Datapath and output next values.
  always_comb begin
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    match_cnt_d  = match_cnt_q;
    idx_d        = idx_q;
    idx_valid_d  = 1'b0;
    onehot_err_d = 1'b0;
    seq_err_d    = 1'b0;
    rev_count_d  = rev_count_q;
    err_count_d  = err_count_q;
    if (en) begin
      if (!is_onehot_c) begin
        onehot_err_d = 1'b1;
        err_count_d  = err_inc_c;
        have_prev_d  = 1'b0;
        match_cnt_d  = '0;
      end else begin
        prev_d      = ring_in;
        idx_d       = enc_c;
        idx_valid_d = 1'b1;
        if (!have_prev_q) begin
          have_prev_d = 1'b1;
          match_cnt_d = '0;
        end else if (match_c) begin
          if (state_q == ST_TRACK) match_cnt_d = match_cnt_q + CNT_W'(1);
          if (state_q == ST_LOCKED && ring_in == 4'b0001)
            rev_count_d = rev_count_q + REV_W'(1);
        end else begin
          seq_err_d   = 1'b1;
          err_count_d = err_inc_c;
          match_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      prev_q       <= '0;
      have_prev_q  <= 1'b0;
      match_cnt_q  <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      onehot_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      rev_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      prev_q       <= prev_d;
      have_prev_q  <= have_prev_d;
      match_cnt_q  <= match_cnt_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      onehot_err_q <= onehot_err_d;
      seq_err_q    <= seq_err_d;
      rev_count_q  <= rev_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign onehot_err = onehot_err_q;
  assign seq_err    = seq_err_q;
  assign locked     = (state_q == ST_LOCKED);
  assign rev_count  = rev_count_q;
  assign err_count  = err_count_q;

endmodule
